// File: rtl/defuzz_pkg.sv
// Shared definitions for the centroid defuzzifier: flag bit positions,
// FSM state encoding and the region center values for the 10-bit datapath.
package defuzz_pkg;

    localparam int FLAG_NEG   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_POS   = 2;
    localparam int FLAG_INV   = 3;
    localparam int FLAG_EMPTY = 3;

    // Region centers sit at +/- one quarter of the 10-bit full scale.
    localparam int CENTER_NEG  = -256;
    localparam int CENTER_ZERO = 0;
    localparam int CENTER_POS  = 256;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/defuzz_div.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Caller guarantees the quotient fits in W bits (dividend < divisor * 2^W).
module defuzz_div #(
    parameter int W  = 10,
    parameter int SW = W + 4,
    parameter int DW = 2 * W + 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [SW-1:0] i_divisor,
    output logic          o_done,
    output logic [W-1:0]  o_quotient,
    output logic [SW-1:0] o_remainder
);

    localparam int CNT_W = $clog2(W + 1);

    logic [SW-1:0]    r_rem;
    logic [SW-1:0]    r_divisor;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_low;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [SW-1:0] w_rem_in;
    logic [SW-1:0] w_dvs;
    logic [SW:0]   w_shift;
    logic [SW-1:0] w_diff;
    logic [SW-1:0] w_rem_next;
    logic          w_bit;
    logic          w_qbit;

    // The start cycle performs the first iteration directly from the inputs,
    // so the upper dividend bits seed the partial remainder.
    assign w_rem_in   = i_start ? i_dividend[DW-1:W] : r_rem;
    assign w_bit      = i_start ? i_dividend[W-1] : r_low[W-1];
    assign w_dvs      = i_start ? i_divisor : r_divisor;
    assign w_shift    = {w_rem_in, w_bit};
    assign w_qbit     = (w_shift >= {1'b0, w_dvs});
    assign w_diff     = w_shift[SW-1:0] - w_dvs;
    assign w_rem_next = w_qbit ? w_diff : w_shift[SW-1:0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_low     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem     <= w_rem_next;
                r_divisor <= i_divisor;
                r_quo     <= {{(W-1){1'b0}}, w_qbit};
                r_low     <= {i_dividend[W-2:0], 1'b0};
                r_cnt     <= CNT_W'(1);
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= {r_quo[W-2:0], w_qbit};
                r_low <= {r_low[W-2:0], 1'b0};
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/defuzz_centroid.sv
// Centroid defuzzifier: accumulates weighted region centers per frame, then
// divides by total weight. Define DEFUZZ_ROUND_EN for round-half-up results.
module defuzz_centroid
    import defuzz_pkg::*;
#(
    parameter int InData_limit = 10,
    parameter int RuleNum      = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    InLast,
    input  logic [3:0]              InFlag,
    input  logic [InData_limit-1:0] InDim,
    output logic                    OutValid,
    output logic [InData_limit-1:0] OutCrisp,
    output logic [3:0]              OutFlag
);

    localparam int W  = InData_limit;
    localparam int SW = W + 4;
    localparam int CW = 2 * W + 4;

    localparam logic signed [CW-1:0] C_NEG  = CW'(CENTER_NEG);
    localparam logic signed [CW-1:0] C_ZERO = CW'(CENTER_ZERO);
    localparam logic signed [CW-1:0] C_POS  = CW'(CENTER_POS);

    state_t                r_state;
    state_t                w_state_next;
    logic [SW-1:0]         r_sum_w;
    logic signed [CW-1:0]  r_sum_wc;
    logic [3:0]            r_cnt;
    logic                  r_empty;
    logic                  r_neg;
    logic [W-1:0]          r_out_crisp;
    logic [3:0]            r_out_flag;

    logic                  w_accept;
    logic                  w_close;
    logic                  w_region_ok;
    logic [W-1:0]          w_weight;
    logic signed [CW-1:0]  w_center;
    logic signed [CW-1:0]  w_contrib;
    logic [SW-1:0]         w_sum_w_next;
    logic signed [CW-1:0]  w_sum_wc_next;
    logic [CW-1:0]         w_mag;
    logic                  w_div_done;
    logic [W-1:0]          w_quo;
    logic [SW-1:0]         w_rem;
    logic                  w_round_up;
    logic [W-1:0]          w_q_mag;
    logic [W-1:0]          w_crisp;
    logic [W-1:0]          w_crisp_final;
    logic [3:0]            w_flag_final;

    assign w_accept    = InValid && (r_state == ST_ACCUM);
    assign w_close     = w_accept && (InLast || (r_cnt == 4'(RuleNum - 1)));
    assign w_region_ok = !InFlag[FLAG_INV] &&
                         (InFlag[FLAG_POS] || InFlag[FLAG_NEG] || InFlag[FLAG_ZERO]);
    assign w_weight    = w_region_ok ? InDim : '0;

    always_comb begin
        w_center = C_ZERO;
        if (InFlag[FLAG_POS]) begin
            w_center = C_POS;
        end else if (InFlag[FLAG_NEG]) begin
            w_center = C_NEG;
        end
    end

    assign w_contrib     = $signed({{(CW-W){1'b0}}, w_weight}) * w_center;
    assign w_sum_w_next  = r_sum_w + SW'(w_weight);
    assign w_sum_wc_next = r_sum_wc + w_contrib;
    assign w_mag         = w_sum_wc_next[CW-1] ? -w_sum_wc_next : w_sum_wc_next;

    // The divider is launched on the closing edge with the updated sums so its
    // W iterations line up with the W DIVIDE cycles.
    defuzz_div #(
        .W  (W),
        .SW (SW),
        .DW (CW)
    ) u_div (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_start     (w_close),
        .i_dividend  (w_mag),
        .i_divisor   (w_sum_w_next),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

`ifdef DEFUZZ_ROUND_EN
    assign w_round_up = ({w_rem, 1'b0} >= {1'b0, r_sum_w});
`else
    assign w_round_up = 1'b0;
`endif

    assign w_q_mag       = w_quo + {{(W-1){1'b0}}, w_round_up};
    assign w_crisp       = r_neg ? -w_q_mag : w_q_mag;
    assign w_crisp_final = r_empty ? '0 : w_crisp;

    always_comb begin
        w_flag_final = 4'b0010;
        if (r_empty) begin
            w_flag_final = 4'b1010;
        end else if (w_crisp_final[W-1]) begin
            w_flag_final = 4'b0001;
        end else if (w_crisp_final != '0) begin
            w_flag_final = 4'b0100;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:  if (w_close) w_state_next = ST_DIVIDE;
            ST_DIVIDE: if (w_div_done) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_ACCUM;
            default:   w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_ACCUM;
            r_sum_w     <= '0;
            r_sum_wc    <= '0;
            r_cnt       <= '0;
            r_empty     <= 1'b0;
            r_neg       <= 1'b0;
            r_out_crisp <= '0;
            r_out_flag  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sum_w  <= w_sum_w_next;
                r_sum_wc <= w_sum_wc_next;
                r_cnt    <= r_cnt + 4'd1;
            end
            if (w_close) begin
                r_empty <= (w_sum_w_next == '0);
                r_neg   <= w_sum_wc_next[CW-1];
            end
            if ((r_state == ST_DIVIDE) && w_div_done) begin
                r_out_crisp <= w_crisp_final;
                r_out_flag  <= w_flag_final;
            end
            if (r_state == ST_DONE) begin
                r_sum_w  <= '0;
                r_sum_wc <= '0;
                r_cnt    <= '0;
            end
        end
    end

    // A reset landing on the DONE cycle suppresses the strobe.
    assign InReady  = (r_state == ST_ACCUM);
    assign OutValid = (r_state == ST_DONE) && !Rst;
    assign OutCrisp = r_out_crisp;
    assign OutFlag  = r_out_flag;

endmodule
